// File: rtl/proc_pkg.sv
// Shared constants for the execute/write-back stage: ALU opcodes, default widths and FSM encoding.
package proc_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_AW = 3;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_MUL = 2'b11;

  localparam int unsigned ALUOP_IMM_BIT = 2;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StMulRun = 1'b1;

endpackage

// File: rtl/execute_wb_if.sv
// Decode-to-execute operand bus plus the register-bank write-back port.
interface execute_wb_if #(
  parameter int unsigned DATA_W = proc_pkg::DEF_DATA_W,
  parameter int unsigned REG_AW = proc_pkg::DEF_REG_AW
);

  logic              in_valid;
  logic [DATA_W-1:0] r1_data;
  logic [DATA_W-1:0] r2_data;
  logic [2:0]        imm_data;
  logic [REG_AW-1:0] rd;
  logic [2:0]        aluop;
  logic              busy;
  logic              wr_en;
  logic [REG_AW-1:0] rd_alu;
  logic [DATA_W-1:0] data_alu;

  modport master (
    output in_valid, r1_data, r2_data, imm_data, rd, aluop,
    input  busy, wr_en, rd_alu, data_alu
  );

  modport slave (
    input  in_valid, r1_data, r2_data, imm_data, rd, aluop,
    output busy, wr_en, rd_alu, data_alu
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier; one partial product per step, low DATA_W bits kept.
module mul_iter
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [CntW-1:0]   cnt_q;

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // The last step's partial product is folded in combinationally so the caller
  // can register the final value on the same edge.
  assign done    = step && (cnt_q == CntW'(DATA_W - 1));
  assign product = acc_d;

endmodule

// File: rtl/execute_wb.sv
// Execute/write-back stage: single-cycle ADD/SUB/AND, iterative MUL, registered write port.
module execute_wb
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input logic         clk,
  input logic         reset,
  execute_wb_if.slave bus
);

  logic [0:0]        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] rd_alu_q, rd_alu_d;
  logic [DATA_W-1:0] data_alu_q, data_alu_d;
  logic [REG_AW-1:0] rd_mul_q, rd_mul_d;

  alu_op_t           op;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_res;
  logic              mul_start;
  logic              mul_step;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign op  = bus.aluop[1:0];
  assign opb = bus.aluop[ALUOP_IMM_BIT] ? {{(DATA_W-3){1'b0}}, bus.imm_data} : bus.r2_data;

  always_comb begin
    alu_res = '0;
    unique case (op)
      ALU_ADD: alu_res = bus.r1_data + opb;
      ALU_SUB: alu_res = bus.r1_data - opb;
      ALU_AND: alu_res = bus.r1_data & opb;
      default: alu_res = '0;
    endcase
  end

  assign mul_start = (state_q == StIdle) && bus.in_valid && (op == ALU_MUL);
  assign mul_step  = (state_q == StMulRun);

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (bus.r1_data),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  // Outputs default to zero so the register bank's unconditional write only touches r0.
  always_comb begin
    state_d    = state_q;
    rd_mul_d   = rd_mul_q;
    wr_en_d    = 1'b0;
    rd_alu_d   = '0;
    data_alu_d = '0;
    if (state_q == StIdle) begin
      if (bus.in_valid) begin
        if (op == ALU_MUL) begin
          state_d  = StMulRun;
          rd_mul_d = bus.rd;
        end else if (bus.rd != '0) begin
          wr_en_d    = 1'b1;
          rd_alu_d   = bus.rd;
          data_alu_d = alu_res;
        end
      end
    end else if (mul_done) begin
      state_d = StIdle;
      if (rd_mul_q != '0) begin
        wr_en_d    = 1'b1;
        rd_alu_d   = rd_mul_q;
        data_alu_d = mul_product;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_mul_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_alu_q   <= '0;
      data_alu_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_mul_q   <= rd_mul_d;
      wr_en_q    <= wr_en_d;
      rd_alu_q   <= rd_alu_d;
      data_alu_q <= data_alu_d;
    end
  end

  assign bus.busy     = (state_q == StMulRun);
  assign bus.wr_en    = wr_en_q;
  assign bus.rd_alu   = rd_alu_q;
  assign bus.data_alu = data_alu_q;

endmodule

// File: tb/tb_execute_wb.sv
// Scoreboard bench for execute_wb: directed plan cases plus random traffic against a cycle model.
module tb_execute_wb;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  execute_wb_if bus ();

  execute_wb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   busy_lo   = -1;
  int   busy_hi   = -2;
  int   idle_from = 0;
  int   n_chk     = 0;
  int   n_fail    = 0;
  bit   mon_en    = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: after edge k (cyc==k) compare the write port against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (bus.wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {31'b0, bus.wr_en}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_cycle", cyc, e.cyc);
          chk("wb_rd", {29'b0, bus.rd_alu}, {29'b0, e.rd});
          chk("wb_data", {16'b0, bus.data_alu}, {16'b0, e.data});
        end
      end else begin
        chk("wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("idle_rd", {29'b0, bus.rd_alu}, 32'd0);
        chk("idle_data", {16'b0, bus.data_alu}, 32'd0);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          chk("missed_write_cycle", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called #1 after a posedge; the inputs are sampled at the next edge.
  task automatic drive(input bit v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] imm, input logic [2:0] rd,
                       output bit accepted);
    int          e;
    int          bval;
    int          res;
    exp_t        x;
    bus.in_valid = v;
    bus.aluop    = op;
    bus.r1_data  = a;
    bus.r2_data  = b;
    bus.imm_data = imm;
    bus.rd       = rd;
    e = cyc + 1;
    accepted = v && reset && (e >= idle_from);
    if (accepted) begin
      bval = op[2] ? int'(imm) : int'(b);
      case (op[1:0])
        2'b00:   res = int'(a) + bval;
        2'b01:   res = int'(a) - bval;
        2'b10:   res = int'(a) & bval;
        default: res = int'(a) * bval;
      endcase
      x.rd   = rd;
      x.data = res[15:0];
      if (op[1:0] == 2'b11) begin
        x.cyc     = e + 16;
        busy_lo   = e;
        busy_hi   = e + 15;
        idle_from = e + 17;
      end else begin
        x.cyc = e;
      end
      if (rd != 3'd0) sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 16'd0, 16'd0, 3'd0, 3'd0, acc);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] imm, input logic [2:0] rd);
    bit acc;
    drive(1'b1, op, a, b, imm, rd, acc);
  endtask

  // Upstream behaviour: hold the instruction until the stage takes it.
  task automatic issue_hold(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] imm, input logic [2:0] rd);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) drive(1'b1, op, a, b, imm, rd, acc);
    chk("accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  // Reset edges with a live ADD on the bus to show reset wins.
  task automatic do_reset(input int n);
    int e;
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.aluop    = 3'b000;
    bus.r1_data  = 16'd1;
    bus.r2_data  = 16'd1;
    bus.imm_data = 3'd0;
    bus.rd       = 3'd1;
    for (int i = 0; i < n; i++) begin
      e = cyc + 1;
      sb.delete();
      if (busy_hi >= e) busy_hi = e - 1;
      idle_from = e + 1;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    bus.in_valid = 1'b0;
    bus.aluop    = 3'b000;
    bus.r1_data  = '0;
    bus.r2_data  = '0;
    bus.imm_data = '0;
    bus.rd       = '0;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(2);
    idle(1);

    issue(3'b000, 16'd5, 16'd5, 3'd0, 3'd3);            // ADD -> 0x000A
    idle(1);
    issue(3'b101, 16'd5, 16'd0, 3'd7, 3'd2);            // SUB imm -> 0xFFFE
    idle(1);
    issue(3'b011, 16'd7, 16'd6, 3'd0, 3'd4);            // MUL -> 0x002A
    idle(18);
    issue(3'b011, 16'h0100, 16'h0100, 3'd0, 3'd6);      // MUL wrap -> 0x0000
    issue_hold(3'b000, 16'd1, 16'd2, 3'd0, 3'd1);       // held ADD accepted after completion
    idle(2);
    issue(3'b010, 16'h00F0, 16'h0FF0, 3'd0, 3'd1);      // back-to-back AND
    issue(3'b000, 16'hFFFF, 16'h0001, 3'd0, 3'd5);      // then ADD wrap
    idle(1);
    issue(3'b000, 16'd5, 16'd5, 3'd0, 3'd0);            // rd=0 suppressed
    idle(2);

    issue(3'b011, 16'd3, 16'd9, 3'd0, 3'd7);            // MUL aborted by reset
    idle(2);
    drive(1'b1, 3'b001, 16'd9, 16'd4, 3'd0, 3'd6, acc); // ignored while busy
    idle(1);
    do_reset(1);                                        // 5th MUL_RUN edge
    issue(3'b000, 16'd2, 16'd3, 3'd0, 3'd3);
    idle(20);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
              16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), acc);
      end
    end
    idle(20);
    chk("scoreboard_drain", sb.size(), 32'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_wb.md
Name: execute_wb

Overview:
Execute/write-back stage. It consumes the operands and control fields produced by the decode unit (r1_data, r2_data, imm_data, rd, aluop) and produces the register-bank write port (rd_alu, data_alu). The decode unit's register bank writes on every posedge with no enable, so this block must drive r0/zero whenever there is nothing to write. ADD/SUB/AND execute in a single cycle. MUL is iterative (shift-add), lasts DATA_W cycles and stalls upstream through busy.

Parameters:
DATA_W, 16, operand/result width.
REG_AW, 3, register address width (8 registers).

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  operand/control set valid this cycle.
r1_data  input  DATA_W  operand A.
r2_data  input  DATA_W  operand B (register form).
imm_data  input  3  immediate, zero-extended to DATA_W.
rd  input  REG_AW  destination register.
aluop  input  3  [1:0] op: 00 ADD, 01 SUB, 10 AND, 11 MUL; [2]=1 selects imm_data as operand B.
busy  output  1  multiply in progress; upstream must hold its instruction.
wr_en  output  1  informational: this cycle's rd_alu/data_alu is a real write.
rd_alu  output  REG_AW  write-back register address.
data_alu  output  DATA_W  write-back data.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, busy=0, wr_en=0, rd_alu=0, data_alu=0, multiplier registers cleared. Reset takes priority over everything, including an in-flight MUL, which is aborted with no write-back.
- Idle write convention: whenever wr_en=0, rd_alu=0 and data_alu=0, so the decode register bank keeps r0 at zero.
- Any result destined for rd==0 is suppressed (wr_en=0, zeros driven).
- Operand B = aluop[2] ? {13'b0, imm_data} : r2_data.
- Arithmetic is modulo 2^DATA_W. SUB = A - B in two's complement. MUL keeps the low DATA_W bits. No flags.
- All outputs are registered.
- FSM states: IDLE, MUL_RUN.
- IDLE, in_valid=0 at posedge N: outputs go to zeros.
- IDLE, in_valid=1 with ADD/SUB/AND at posedge N: result, rd and wr_en are registered at edge N and are visible for the cycle N..N+1, so decode writes them at edge N+1. Latency is 1 and throughput is 1 per cycle; back-to-back ops are allowed.
- IDLE, in_valid=1 with MUL at posedge N:
  - Load mcand=A, mplier=B, acc=0, cnt=0, and latch rd.
  - Go to MUL_RUN; busy=1 after edge N. Outputs are zero during MUL_RUN.
- MUL_RUN, each posedge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
- MUL completion: on the edge where cnt==DATA_W-1 (edge N+DATA_W), register acc-final, the latched rd and wr_en, then return to IDLE with busy=0. For DATA_W=16, busy is high for exactly 16 cycles.
- in_valid while busy is ignored. Upstream re-presents the held instruction, and it is accepted on the first IDLE edge after completion. The completion edge itself does not accept.
- No early termination on mplier==0; latency is fixed.

Decomposition:
- Shared package (proc_pkg) holds:
  - ALU_ADD/SUB/AND/MUL 2-bit constants.
  - ALUOP_IMM_BIT=2.
  - DATA_W and REG_AW defaults.
  - FSM state encoding.
- One natural sub-module: mul_iter. It holds the shift-add datapath (mcand, mplier, acc, cnt) with a start/done interface. execute_wb keeps the FSM, the single-cycle ALU and the output registers.

Test Plan:
- ADD: r1=5, r2=5, rd=3, aluop=000, in_valid=1 for one edge -> next cycle wr_en=1, rd_alu=3, data_alu=0x000A; the following cycle returns to zeros.
- SUB immediate: r1=5, imm=7, aluop=101, rd=2 -> rd_alu=2, data_alu=0xFFFE.
- MUL: r1=7, r2=6, aluop=011, rd=4 -> busy high for exactly 16 cycles, outputs zero meanwhile, then one cycle of rd_alu=4, data_alu=0x002A. Also 0x0100*0x0100 -> data_alu=0x0000 (wrap).
- Back-to-back: AND 0x00F0&0x0FF0 to rd=1, then OR-free ADD 0xFFFF+1 to rd=5 on consecutive edges -> 0x00F0 then 0x0000 on consecutive cycles, both with wr_en=1.
- rd=0 suppression: ADD 5+5, rd=0 -> wr_en=0, rd_alu=0, data_alu=0.
- Reset mid-MUL: reset=0 at the 5th MUL_RUN edge -> busy=0 and all outputs zero next cycle, and no write-back ever appears. A new ADD accepted after reset works normally. An in_valid pulse with a different op while busy has no effect.
